// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with whole-scan debounce
module keypad_scanner #(
  parameter int ROW_DWELL    = 49999,
  parameter int STABLE_SCANS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [17:0] DWELL_MAX  = 18'(ROW_DWELL);
  localparam logic [3:0]  STABLE_MIN = 4'(STABLE_SCANS);

  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_kind_t;

  logic [17:0] dwell_cnt;
  logic [1:0]  row_idx;
  res_kind_t   acc_kind, nxt_kind, scan_kind, prev_kind;
  logic [3:0]  acc_code, nxt_code, scan_code, prev_code;
  logic        scan_done;
  logic [3:0]  stable_cnt, stable_nxt;
  logic        armed, armed_eff, changed, is_stable;
  logic [3:0]  low;
  logic [2:0]  low_cnt;
  logic [1:0]  col_pos;
  logic        sample_now;

  assign row        = ~(4'b0001 << row_idx);
  assign low        = ~col;
  assign sample_now = (dwell_cnt == DWELL_MAX);
  assign low_cnt    = {2'b00, low[0]} + {2'b00, low[1]} + {2'b00, low[2]} + {2'b00, low[3]};

  always_comb begin
    col_pos = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (low[i]) col_pos = 2'(i);
    end
  end

  // Fold this row's sample into the scan result; code is kept 0 unless SINGLE so results compare directly.
  always_comb begin
    nxt_kind = acc_kind;
    nxt_code = acc_code;
    if (low_cnt >= 3'd2) begin
      nxt_kind = RES_MULTI;
      nxt_code = 4'd0;
    end else if (low_cnt == 3'd1) begin
      if (acc_kind == RES_NONE) begin
        nxt_kind = RES_SINGLE;
        nxt_code = {row_idx, col_pos};
      end else begin
        nxt_kind = RES_MULTI;
        nxt_code = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= 18'd0;
      row_idx   <= 2'd0;
      acc_kind  <= RES_NONE;
      acc_code  <= 4'd0;
      scan_kind <= RES_NONE;
      scan_code <= 4'd0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (sample_now) begin
        dwell_cnt <= 18'd0;
        row_idx   <= row_idx + 2'd1;
        if (row_idx == 2'd3) begin
          scan_kind <= nxt_kind;
          scan_code <= nxt_code;
          scan_done <= 1'b1;
          acc_kind  <= RES_NONE;
          acc_code  <= 4'd0;
        end else begin
          acc_kind <= nxt_kind;
          acc_code <= nxt_code;
        end
      end else begin
        dwell_cnt <= dwell_cnt + 18'd1;
      end
    end
  end

  // A changed result re-arms in the same evaluation, so STABLE_SCANS=1 reports immediately.
  always_comb begin
    changed    = (scan_kind != prev_kind) || (scan_code != prev_code);
    stable_nxt = changed ? 4'd1 : ((stable_cnt == 4'd15) ? 4'd15 : stable_cnt + 4'd1);
    armed_eff  = armed | changed;
    is_stable  = (stable_nxt >= STABLE_MIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_kind  <= RES_NONE;
      prev_code  <= 4'd0;
      stable_cnt <= 4'd0;
      armed      <= 1'b1;
      key_code   <= 4'd0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (scan_done) begin
        prev_kind  <= scan_kind;
        prev_code  <= scan_code;
        stable_cnt <= stable_nxt;
        armed      <= armed_eff;
        if (is_stable) begin
          if (scan_kind == RES_SINGLE) begin
            if (armed_eff) begin
              key_code  <= scan_code;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              armed     <= 1'b0;
            end
          end else begin
            key_held <= 1'b0;
            armed    <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with an emulated keypad
module tb_keypad_scanner;

  localparam int RD  = 3;
  localparam int SS  = 2;
  localparam int DW  = RD + 1;
  localparam int SCN = 4 * DW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [15:0] keys = 16'h0;

  int total = 0;
  int bad   = 0;

  typedef struct {int code; int edge_idx;} exp_t;
  exp_t exp_q[$];

  int ncyc = 0;
  int hits[$];
  int prev_res, stable, m_code;
  bit armed, m_held;

  keypad_scanner #(.ROW_DWELL(RD), .STABLE_SCANS(SS)) dut (
    .clk(clk), .rst_n(rst_n), .col(col), .row(row),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row[r])
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c]) col[c] = 1'b0;
  end

  // Reference model: result = list of pressed codes seen at the 4 sample instants of a scan.
  always @(posedge clk) begin
    if (!rst_n) begin
      ncyc = 0; hits.delete(); prev_res = -1; stable = 0; armed = 1;
      m_held = 0; m_code = 0; exp_q.delete();
    end else begin
      if (ncyc % SCN == 0 && ncyc > 0) begin
        int res;
        bit chg;
        res = (hits.size() == 0) ? -1 : ((hits.size() == 1) ? hits[0] : -2);
        hits.delete();
        chg = (res != prev_res);
        if (chg) begin stable = 1; prev_res = res; armed = 1; end
        else if (stable < 15) stable++;
        if (stable >= SS) begin
          if (res >= 0) begin
            if (armed) begin
              m_code = res; m_held = 1; armed = 0;
              exp_q.push_back('{res, ncyc});
            end
          end else begin
            m_held = 0; armed = 1;
          end
        end
      end
      if (ncyc % DW == RD) begin
        int r;
        r = (ncyc / DW) % 4;
        for (int c = 0; c < 4; c++) if (keys[r*4+c]) hits.push_back(r*4+c);
      end
      ncyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic [3:0] exp_row;
      exp_row = ~(4'b0001 << ((ncyc / DW) % 4));
      total++;
      if (row !== exp_row) begin bad++; $display("FAIL row cyc=%0d got=%b exp=%b", ncyc, row, exp_row); end
      total++;
      if (key_held !== m_held) begin bad++; $display("FAIL key_held cyc=%0d got=%b exp=%b", ncyc, key_held, m_held); end
      total++;
      if (key_code !== 4'(m_code)) begin bad++; $display("FAIL key_code cyc=%0d got=%h exp=%h", ncyc, key_code, m_code); end
      if (key_valid !== 1'b0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL pulse cyc=%0d got=unexpected key_valid=%b exp=none", ncyc, key_valid);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (key_code !== 4'(e.code) || e.edge_idx != ncyc - 1) begin
            bad++;
            $display("FAIL pulse got code=%h edge=%0d exp code=%h edge=%0d", key_code, ncyc - 1, e.code, e.edge_idx);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].edge_idx < ncyc - 1) begin
        exp_t e;
        e = exp_q.pop_front();
        total++; bad++;
        $display("FAIL missed_pulse got=none exp code=%h edge=%0d", e.code, e.edge_idx);
      end
    end
  end

  task automatic run(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin bad++; $display("FAIL %s got=%b exp=%b", name, got, exp); end
  endtask

  initial begin
    run(3);
    chk("reset_row", row, 4'b1110);
    chk("reset_valid", {3'b0, key_valid}, 4'b0);
    chk("reset_held", {3'b0, key_held}, 4'b0);
    chk("reset_code", key_code, 4'b0);
    rst_n = 1'b1;
    run(4 * SCN);

    keys = 16'h0200;               // row2/col1
    run(12 * SCN);

    keys = 16'h0; run(3 * SCN);
    for (int i = 0; i < 10; i++) begin keys = keys ^ 16'h0200; run(5); end
    keys = 16'h0200; run(5 * SCN);

    keys = 16'h0; run(2 * SCN);
    keys = 16'h0200; run(4 * SCN);

    keys = 16'h0021; run(4 * SCN); // keys 0 and 5
    keys = 16'h0001; run(4 * SCN);

    // Async reset mid-scan while the key is held.
    for (int i = 0; i < SCN && (ncyc % SCN) != 6; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_row", row, 4'b1110);
    chk("midrst_valid", {3'b0, key_valid}, 4'b0);
    chk("midrst_held", {3'b0, key_held}, 4'b0);
    chk("midrst_code", key_code, 4'b0);
    run(2);
    rst_n = 1'b1;
    run(4 * SCN);

    for (int p = 0; p < 24; p++) begin
      int k;
      k = $urandom_range(0, 2);
      keys = 16'h0;
      if (k >= 1) keys[$urandom_range(0, 15)] = 1'b1;
      if (k == 2) keys[$urandom_range(0, 15)] = 1'b1;
      run($urandom_range(3, 3 * SCN));
    end
    keys = 16'h0; run(4 * SCN);

    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL pending_pulses got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
